// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch FSM state encoding.
package pipeline_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold, bubble-load and normal-load controls.
import pipeline_pkg::*;

module if_id_reg #(
  parameter logic [PC_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Hold,
  input  logic            LoadBubble,
  input  logic            Load,
  input  logic [PC_W-1:0] Instr,
  input  logic [PC_W-1:0] PCPlus4,
  output logic [PC_W-1:0] InstrQ,
  output logic [PC_W-1:0] PCPlus4Q,
  output logic            ValidQ
);

  // Hold wins over any load; a bubble wins over a normal capture.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      InstrQ   <= NOP_INSTR;
      PCPlus4Q <= '0;
      ValidQ   <= 1'b0;
    end else if (Hold) begin
      InstrQ   <= InstrQ;
      PCPlus4Q <= PCPlus4Q;
      ValidQ   <= ValidQ;
    end else if (LoadBubble) begin
      InstrQ   <= NOP_INSTR;
      PCPlus4Q <= '0;
      ValidQ   <= 1'b0;
    end else if (Load) begin
      InstrQ   <= Instr;
      PCPlus4Q <= PCPlus4;
      ValidQ   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, deferred-redirect FSM and IF/ID register.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the instruction after a branch.
import pipeline_pkg::*;

module fetch_stage #(
  parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [PC_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Stall,
  input  logic            Redirect,
  input  logic [PC_W-1:0] RedirectPC,
  input  logic [PC_W-1:0] IMemData,
  output logic [PC_W-1:0] IMemAddr,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] IF_ID_Instruction,
  output logic [PC_W-1:0] IF_ID_PCPlus4,
  output logic            IF_ID_Valid
);

  fetch_state_t    state;
  logic [PC_W-1:0] pending_pc;
  logic [PC_W-1:0] aligned_target;
  logic [PC_W-1:0] pc_plus4;
  logic            take_redirect;
  logic            load_bubble;
  logic            load_normal;

  assign aligned_target = {RedirectPC[PC_W-1:2], 2'b00};
  assign pc_plus4       = PC + 32'd4;
  assign IMemAddr       = PC;

  // A redirect lands on the first unstalled cycle, whether fresh or deferred.
  assign take_redirect = !Stall && (Redirect || (state == PEND));

`ifdef BRANCH_DELAY_SLOT_EN
  assign load_bubble = 1'b0;
  assign load_normal = !Stall;
`else
  assign load_bubble = take_redirect;
  assign load_normal = !Stall && !take_redirect;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      PC         <= RESET_PC;
      pending_pc <= '0;
      state      <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (Stall) begin
            if (Redirect) begin
              pending_pc <= aligned_target;
              state      <= PEND;
            end
          end else if (Redirect) begin
            PC <= aligned_target;
          end else begin
            PC <= pc_plus4;
          end
        end
        PEND: begin
          if (Stall) begin
            if (Redirect) pending_pc <= aligned_target;
          end else begin
            PC    <= Redirect ? aligned_target : pending_pc;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .Clk       (Clk),
    .Rst       (Rst),
    .Hold      (Stall),
    .LoadBubble(load_bubble),
    .Load      (load_normal),
    .Instr     (IMemData),
    .PCPlus4   (pc_plus4),
    .InstrQ    (IF_ID_Instruction),
    .PCPlus4Q  (IF_ID_PCPlus4),
    .ValidQ    (IF_ID_Valid)
  );

endmodule
